// File: rtl/nibble_pkg.sv
// rtl/nibble_pkg.sv - shared types, widths and helpers for the nibble updater
package nibble_pkg;

    localparam int NIB_W       = 4;
    localparam int MAX_NIBBLES = 16;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } upd_state_t;

    // Lowest index holding a zero; MAX_NIBBLES when the mask is all-ones.
    // Callers narrower than MAX_NIBBLES pad the unused upper bits with ones.
    function automatic int first_zero(input logic [MAX_NIBBLES-1:0] mask);
        int idx;
        idx = MAX_NIBBLES;
        for (int i = MAX_NIBBLES - 1; i >= 0; i--) begin
            if (!mask[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/nibble_updater_if.sv
// rtl/nibble_updater_if.sv - control/status bundle between a control unit and the nibble updater
interface nibble_updater_if #(
    parameter int NIBBLES = 4,
    parameter int CW      = $clog2(NIBBLES + 1)
);
    import nibble_pkg::*;

    logic                       start;
    logic [NIB_W*NIBBLES-1:0]   target;
    logic                       clr;
    logic [NIB_W*NIBBLES-1:0]   word;
    logic [NIBBLES-1:0]         eq_mask;
    logic                       busy;
    logic                       done;
    logic [CW-1:0]              fixes;

    modport master (
        output start, target, clr,
        input  word, eq_mask, busy, done, fixes
    );

    modport slave (
        input  start, target, clr,
        output word, eq_mask, busy, done, fixes
    );

endinterface

// File: rtl/nibble_eq_mask.sv
// rtl/nibble_eq_mask.sv - per-nibble equality mask of two words
module nibble_eq_mask
    import nibble_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic [NIB_W*NIBBLES-1:0] a,
    input  logic [NIB_W*NIBBLES-1:0] b,
    output logic [NIBBLES-1:0]       eq
);

    // One XNOR-AND chain per nibble: set only when every bit matches.
    for (genvar k = 0; k < NIBBLES; k++) begin : g_nib
        assign eq[k] = &(a[k*NIB_W +: NIB_W] ~^ b[k*NIB_W +: NIB_W]);
    end

endmodule

// File: rtl/nibble_updater.sv
// rtl/nibble_updater.sv - rewrites the held word toward a latched target, one nibble per clock
module nibble_updater
    import nibble_pkg::*;
#(
    parameter int NIBBLES = 4,
    parameter int CW      = $clog2(NIBBLES + 1)
) (
    input  logic           clk,
    input  logic           rst_n,
    nibble_updater_if.slave bus
);

    localparam int W = NIB_W * NIBBLES;

    upd_state_t               state_q, state_d;
    logic [W-1:0]             word_q, word_d;
    logic [W-1:0]             tgt_q, tgt_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic [CW-1:0]            fixes_q, fixes_d;
    logic [NIBBLES-1:0]       eq;
    logic [MAX_NIBBLES-1:0]   mask_pad;
    int                       fz;

    nibble_eq_mask #(.NIBBLES(NIBBLES)) u_eq (
        .a  (word_q),
        .b  (tgt_q),
        .eq (eq)
    );

    // State and datapath registers; a reset mid-update discards it without a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            word_q  <= '0;
            tgt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            fixes_q <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            tgt_q   <= tgt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            fixes_q <= fixes_d;
        end
    end

    // Next state: accept start (over clr) in IDLE, then fix the lowest mismatched nibble each RUN cycle.
    always_comb begin
        state_d  = state_q;
        word_d   = word_q;
        tgt_d    = tgt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        fixes_d  = fixes_q;
        mask_pad = '1;
        mask_pad[NIBBLES-1:0] = eq;
        fz       = first_zero(mask_pad);

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    tgt_d   = bus.target;
                    fixes_d = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end else if (bus.clr) begin
                    word_d = '0;
                end
            end
            RUN: begin
                if (&eq) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    for (int k = 0; k < NIBBLES; k++) begin
                        if (k == fz) begin
                            word_d[k*NIB_W +: NIB_W] = tgt_q[k*NIB_W +: NIB_W];
                        end
                    end
                    fixes_d = fixes_q + CW'(1);
                end
            end
        endcase
    end

    assign bus.word    = word_q;
    assign bus.eq_mask = eq;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.fixes   = fixes_q;

endmodule
